// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 clock, frames
// 11-bit device-to-host packets (start, 8 data LSB first, odd parity, stop),
// folds E0/F0 prefixes into flags and emits one strobe per scan code.
// Receive only; the PS/2 lines are never driven.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       code_valid_o,
  output logic       extended_o,
  output logic       release_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     BYTE_EXT  = 8'hE0;
  localparam logic [7:0]     BYTE_REL  = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Synchroniser and filter state
  logic           clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall_s;

  // Timeout counter
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic           tmo_hit_s;

  // Frame FSM and datapath
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           ext_pend_q, ext_pend_d;
  logic           rel_pend_q, rel_pend_d;

  // Registered outputs
  logic [7:0]     code_q, code_d;
  logic           code_valid_q, code_valid_d;
  logic           ext_q, ext_d;
  logic           rel_q, rel_d;
  logic           parity_err_q, parity_err_d;
  logic           frame_err_q, frame_err_d;
  logic           busy_q, busy_d;

  // Two-flop synchronisers for both asynchronous PS/2 lines; idle bus reads high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk_i;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data_i;
      data_s2_q <= data_s1_q;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d     = clk_s2_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  assign fall_s = filt_q & ~filt_d;

  // Filter level and run-length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Terminal count only matters while a frame is open.
  assign tmo_hit_s = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_LAST);

  // Inter-bit timer: cleared by each Fall, held at zero when idle.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == ST_IDLE) || fall_s || tmo_hit_s) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TCW'(1);
    end
  end

  // Timer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Frame FSM next state, prefix tracking and output strobes; timeout beats a coincident Fall.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    ext_pend_d   = ext_pend_q;
    rel_pend_d   = rel_pend_q;
    code_d       = code_q;
    ext_d        = ext_q;
    rel_d        = rel_q;
    code_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    if (tmo_hit_s) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      rel_pend_d  = 1'b0;
    end else if (fall_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d = {data_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          par_d   = data_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!data_s2_q) begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            rel_pend_d  = 1'b0;
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            parity_err_d = 1'b1;
            ext_pend_d   = 1'b0;
            rel_pend_d   = 1'b0;
          end else if (shift_q == BYTE_EXT) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == BYTE_REL) begin
            rel_pend_d = 1'b1;
          end else begin
            code_d       = shift_q;
            ext_d        = ext_pend_q;
            rel_d        = rel_pend_q;
            code_valid_d = 1'b1;
            ext_pend_d   = 1'b0;
            rel_pend_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // FSM, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      ext_pend_q   <= 1'b0;
      rel_pend_q   <= 1'b0;
      code_q       <= 8'h00;
      code_valid_q <= 1'b0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      ext_pend_q   <= ext_pend_d;
      rel_pend_q   <= rel_pend_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      ext_q        <= ext_d;
      rel_q        <= rel_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign code_o       = code_q;
  assign code_valid_o = code_valid_q;
  assign extended_o   = ext_q;
  assign release_o    = rel_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed scenarios plus random frames, checked
// against an event-level model of the PS/2 scan-code protocol.
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TMO        = 20000;
  localparam int HALF       = 30;   // PS/2 half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code_o;
  logic       code_valid_o, extended_o, release_o, parity_err_o, frame_err_o, busy_o;

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .code_o(code_o), .code_valid_o(code_valid_o), .extended_o(extended_o),
    .release_o(release_o), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;

  // Events: {kind[1:0], ext, rel, code[7:0]}; kind 0 = code, 1 = parity err, 2 = frame err
  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];

  // Model state: pending prefixes and last reported code
  logic       m_ext = 1'b0, m_rel = 1'b0;
  logic [7:0] m_code = 8'h00;
  logic       m_code_ext = 1'b0, m_code_rel = 1'b0;

  // Record every output strobe seen, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (code_valid_o) obs_q.push_back({2'd0, extended_o, release_o, code_o});
      if (parity_err_o) obs_q.push_back({2'd1, 10'd0});
      if (frame_err_o)  obs_q.push_back({2'd2, 10'd0});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits bits of a frame: start, data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int nbits);
    logic [10:0] fr;
    fr = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Protocol model for one complete frame.
  task automatic model_frame(input logic [7:0] b, input logic par, input logic stp);
    int ones;
    ones = $countones(b) + int'(par);
    if (!stp) begin
      exp_q.push_back({2'd2, 10'd0});
      m_ext = 1'b0; m_rel = 1'b0;
    end else if ((ones % 2) == 0) begin
      exp_q.push_back({2'd1, 10'd0});
      m_ext = 1'b0; m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      exp_q.push_back({2'd0, m_ext, m_rel, b});
      m_code = b; m_code_ext = m_ext; m_code_rel = m_rel;
      m_ext = 1'b0; m_rel = 1'b0;
    end
  endtask

  task automatic check_events(input string tag);
    wait_clks(4);
    chk($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) chk($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
    end
    chk($sformatf("%s_code", tag), code_o, m_code);
    chk($sformatf("%s_ext", tag), extended_o, m_code_ext);
    chk($sformatf("%s_rel", tag), release_o, m_code_rel);
    chk($sformatf("%s_busy", tag), busy_o, 1'b0);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic frame(input logic [7:0] b, input logic par, input logic stp);
    send_frame(b, par, stp, 11);
    model_frame(b, par, stp);
    wait_clks(HALF);
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  initial begin
    logic [7:0] rb;
    logic       rp, rs;
    int         kind, k;

    // Reset values
    wait_clks(5);
    chk("rst_code", code_o, 8'h00);
    chk("rst_valid", code_valid_o, 1'b0);
    chk("rst_ext", extended_o, 1'b0);
    chk("rst_rel", release_o, 1'b0);
    chk("rst_perr", parity_err_o, 1'b0);
    chk("rst_ferr", frame_err_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    reset = 1'b0;
    wait_clks(20);

    // 1: plain make code
    frame(8'h1C, 1'b0, 1'b1);
    check_events("t1");

    // 2: break code
    frame(8'hF0, good_par(8'hF0), 1'b1);
    chk("t2_no_strobe_after_prefix", obs_q.size(), 0);
    frame(8'h1C, good_par(8'h1C), 1'b1);
    check_events("t2");

    // 3: extended break, then plain code clears flags
    frame(8'hE0, good_par(8'hE0), 1'b1);
    frame(8'hF0, good_par(8'hF0), 1'b1);
    frame(8'h74, good_par(8'h74), 1'b1);
    check_events("t3a");
    frame(8'h29, good_par(8'h29), 1'b1);
    check_events("t3b");

    // 4: parity error, then stop error on a prefix, then clean code
    frame(8'h1C, 1'b1, 1'b1);
    check_events("t4a");
    frame(8'hF0, good_par(8'hF0), 1'b0);
    check_events("t4b");
    frame(8'h1C, good_par(8'h1C), 1'b1);
    check_events("t4c");

    // 5: pending E0 then truncated frame -> timeout clears it
    frame(8'hE0, good_par(8'hE0), 1'b1);
    send_frame(8'h15, 1'b0, 1'b1, 6);
    chk("t5_busy_open", busy_o, 1'b1);
    exp_q.push_back({2'd2, 10'd0});
    m_ext = 1'b0; m_rel = 1'b0;
    k = 0;
    while (!frame_err_o && k < TMO + 5000) begin
      wait_clks(1);
      k++;
    end
    // HALF cycles already elapsed since the last falling edge inside send_frame
    chk("t5_tmo_latency_ok", ((k + HALF) >= TMO) && ((k + HALF) <= TMO + FILTER_LEN + 4), 1'b1);
    wait_clks(1);
    chk("t5_ferr_one_cycle", frame_err_o, 1'b0);
    chk("t5_busy_closed", busy_o, 1'b0);
    check_events("t5a");
    frame(8'h5A, good_par(8'h5A), 1'b1);
    check_events("t5b");

    // 6a: short low glitches with data low never start a frame
    ps2_data = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      wait_clks((g == 3) ? FILTER_LEN - 1 : 3);
      ps2_clk = 1'b1;
      wait_clks(15);
      chk($sformatf("t6_glitch%0d_busy", g), busy_o, 1'b0);
    end
    ps2_data = 1'b1;
    check_events("t6a");

    // 6b: reset in the middle of a frame
    send_frame(8'h1C, 1'b0, 1'b1, 4);
    chk("t6_busy_mid", busy_o, 1'b1);
    reset = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(1);
    chk("t6_busy_after_rst", busy_o, 1'b0);
    m_ext = 1'b0; m_rel = 1'b0; m_code = 8'h00; m_code_ext = 1'b0; m_code_rel = 1'b0;
    wait_clks(HALF);
    check_events("t6b");
    frame(8'h1C, good_par(8'h1C), 1'b1);
    check_events("t6c");

    // Random frames with prefixes and injected errors
    for (int r = 0; r < 20; r++) begin
      rb = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 7);
      if (kind == 0) rb = 8'hE0;
      if (kind == 1) rb = 8'hF0;
      rp = good_par(rb);
      if (kind == 2) rp = ~rp;
      rs = (kind == 3) ? 1'b0 : 1'b1;
      frame(rb, rp, rs);
      check_events($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
